// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX operand forwarding selects.
// Optional feature macro: ID_EX_FWD_EN (forwarding on; otherwise hazards stall until the writer retires).
module id_ex_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic [REG_AW-1:0]     id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_reg_we,
  input  logic                  id_mem_rd,
  input  logic                  id_alu_src_1_ctr,
  input  logic                  id_alu_src_2_ctr,
  input  logic [3:0]            id_alu_op,
  input  logic                  flush,
  input  logic                  ex_hold,
  input  logic                  exmem_valid,
  input  logic                  exmem_reg_we,
  input  logic [REG_AW-1:0]     exmem_rd,
  input  logic                  memwb_valid,
  input  logic                  memwb_reg_we,
  input  logic [REG_AW-1:0]     memwb_rd,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_rd1,
  output logic [DATA_WIDTH-1:0] ex_rd2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [REG_AW-1:0]     ex_rd,
  output logic                  ex_reg_we,
  output logic                  ex_mem_rd,
  output logic                  ex_alu_src_1_ctr,
  output logic                  ex_alu_src_2_ctr,
  output logic [3:0]            ex_alu_op,
  output logic [1:0]            rd1_ctr,
  output logic [1:0]            rd2_ctr,
  output logic                  stall_id
);

  localparam int unsigned OP_W = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [REG_AW-1:0]     rs1;
    logic [REG_AW-1:0]     rs2;
    logic [REG_AW-1:0]     rd;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  reg_we;
    logic                  mem_rd;
    logic                  alu_src_1_ctr;
    logic                  alu_src_2_ctr;
    logic [OP_W-1:0]       alu_op;
  } ex_regs_t;

  typedef enum logic [1:0] {
    UPD_LOAD   = 2'd0,
    UPD_HOLD   = 2'd1,
    UPD_BUBBLE = 2'd2
  } upd_e;

  ex_regs_t ex_q;
  ex_regs_t ex_d;
  logic     ex_valid_q;
  logic     ex_valid_d;
  upd_e     upd;
  logic     lu;
  logic [1:0] rd1_sel;
  logic [1:0] rd2_sel;

  // True when a non-x0 destination matches a source the ID instruction really reads.
  function automatic logic id_reads(input logic [REG_AW-1:0] wr_rd,
                                    input logic u1, input logic [REG_AW-1:0] r1,
                                    input logic u2, input logic [REG_AW-1:0] r2);
    return (wr_rd != '0) && ((u1 && (r1 == wr_rd)) || (u2 && (r2 == wr_rd)));
  endfunction

`ifdef ID_EX_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_AW-1:0] rs,
                                         input logic em_v, input logic em_we, input logic [REG_AW-1:0] em_rd,
                                         input logic mw_v, input logic mw_we, input logic [REG_AW-1:0] mw_rd);
    if (uses && em_v && em_we && (em_rd != '0) && (em_rd == rs)) return 2'b01;
    if (uses && mw_v && mw_we && (mw_rd != '0) && (mw_rd == rs)) return 2'b10;
    return 2'b00;
  endfunction
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_q.rs1, ex_q.rs2, ex_q.uses_rs1, ex_q.uses_rs2};
`endif

  // Hazard detection and forwarding selects.
  always_comb begin
    lu      = 1'b0;
    rd1_sel = 2'b00;
    rd2_sel = 2'b00;
`ifdef ID_EX_FWD_EN
    lu = ex_valid_q && ex_q.mem_rd && ex_q.reg_we &&
         id_reads(ex_q.rd, id_uses_rs1, id_rs1, id_uses_rs2, id_rs2);
    rd1_sel = fwd_sel(ex_q.uses_rs1, ex_q.rs1, exmem_valid, exmem_reg_we, exmem_rd,
                      memwb_valid, memwb_reg_we, memwb_rd);
    rd2_sel = fwd_sel(ex_q.uses_rs2, ex_q.rs2, exmem_valid, exmem_reg_we, exmem_rd,
                      memwb_valid, memwb_reg_we, memwb_rd);
`else
    lu = (ex_valid_q && ex_q.reg_we &&
          id_reads(ex_q.rd, id_uses_rs1, id_rs1, id_uses_rs2, id_rs2)) ||
         (exmem_valid && exmem_reg_we &&
          id_reads(exmem_rd, id_uses_rs1, id_rs1, id_uses_rs2, id_rs2)) ||
         (memwb_valid && memwb_reg_we &&
          id_reads(memwb_rd, id_uses_rs1, id_rs1, id_uses_rs2, id_rs2));
`endif
    lu = lu && id_valid;
  end

  // Per-cycle update decision: flush beats hold beats load-use.
  always_comb begin
    upd = UPD_LOAD;
    if (flush)        upd = UPD_BUBBLE;
    else if (ex_hold) upd = UPD_HOLD;
    else if (lu)      upd = UPD_BUBBLE;
  end

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    case (upd)
      UPD_LOAD: begin
        ex_valid_d         = id_valid;
        ex_d.pc            = id_pc;
        ex_d.rd1           = id_rd1;
        ex_d.rd2           = id_rd2;
        ex_d.imm           = id_imm;
        ex_d.rs1           = id_rs1;
        ex_d.rs2           = id_rs2;
        ex_d.rd            = id_rd;
        ex_d.uses_rs1      = id_uses_rs1;
        ex_d.uses_rs2      = id_uses_rs2;
        ex_d.reg_we        = id_reg_we;
        ex_d.mem_rd        = id_mem_rd;
        ex_d.alu_src_1_ctr = id_alu_src_1_ctr;
        ex_d.alu_src_2_ctr = id_alu_src_2_ctr;
        ex_d.alu_op        = id_alu_op;
      end
      UPD_BUBBLE: ex_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid         = ex_valid_q;
  assign ex_pc            = ex_q.pc;
  assign ex_rd1           = ex_q.rd1;
  assign ex_rd2           = ex_q.rd2;
  assign ex_imm           = ex_q.imm;
  assign ex_rd            = ex_q.rd;
  assign ex_reg_we        = ex_valid_q & ex_q.reg_we;
  assign ex_mem_rd        = ex_valid_q & ex_q.mem_rd;
  assign ex_alu_src_1_ctr = ex_q.alu_src_1_ctr;
  assign ex_alu_src_2_ctr = ex_q.alu_src_2_ctr;
  assign ex_alu_op        = ex_q.alu_op;
  assign rd1_ctr          = rd1_sel;
  assign rd2_ctr          = rd2_sel;
  assign stall_id         = !flush && (ex_hold || lu);

endmodule
